// File: rtl/rx_ctrl_pkg.sv
// Shared types and default timing constants for the receiver power-up sequencer.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIAS   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  localparam int BIAS_CYCLES_DEF   = 40;
  localparam int SETTLE_CYCLES_DEF = 60;
  localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/rx_ctrl_sync.sv
// Generic 2-flop synchroniser with asynchronous active-high reset to 0.
module rx_ctrl_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rx_ctrl.sv
// Receiver power-up sequencer: IDLE -> BIAS -> SETTLE -> READY, RDY_RX registered.
// Define RX_CTRL_SYNC_EN to pass PU_RX through a 2-flop synchroniser.
module rx_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int BIAS_CYCLES   = BIAS_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic PU_RX,
  output logic RDY_RX
);

  localparam logic [CNT_W-1:0] BIAS_TC   = CNT_W'(BIAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

  logic pu_s;

`ifdef RX_CTRL_SYNC_EN
  rx_ctrl_sync #(.WIDTH(1)) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (PU_RX),
    .q_o   (pu_s)
  );
`else
  assign pu_s = PU_RX;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    // A dropped request wins over any terminal-count transition.
    if (!pu_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_BIAS;
        ST_BIAS:   if (cnt_q == BIAS_TC) state_d = ST_SETTLE;
                   else cnt_d = cnt_q + CNT_W'(1);
        ST_SETTLE: if (cnt_q == SETTLE_TC) state_d = ST_READY;
                   else cnt_d = cnt_q + CNT_W'(1);
        ST_READY:  state_d = ST_READY;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_READY);
    end
  end

  assign RDY_RX = rdy_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed self-checking bench for rx_ctrl; latencies adapt to RX_CTRL_SYNC_EN.
module tb_rx_ctrl;
  import rx_ctrl_pkg::*;

`ifdef RX_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  // Edges counted from the first edge that samples PU_RX=1 (that edge is 1).
  localparam int RISE = LAT + BIAS_CYCLES_DEF + SETTLE_CYCLES_DEF + 1;
  localparam int MAX_WAIT = 400;

  logic CLK = 1'b0;
  logic RST;
  logic PU_RX;
  logic RDY_RX;

  int checks = 0;
  int errors = 0;

  always #100 CLK = ~CLK;

  rx_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .PU_RX  (PU_RX),
    .RDY_RX (RDY_RX)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges until RDY_RX rises; also confirms it is still low at edge 100.
  task automatic measure_rise(input string tag, output int n);
    n = 0;
    while (RDY_RX !== 1'b1 && n < MAX_WAIT) begin
      tick();
      n++;
      if (n == 100) check({tag, "_low_at_100"}, 32'(RDY_RX), 32'd0);
    end
  endtask

  task automatic measure_fall(output int n);
    n = 0;
    while (RDY_RX !== 1'b0 && n < MAX_WAIT) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bad;

    // Reset asserted with the request already high.
    RST   = 1'b1;
    PU_RX = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RDY_RX !== 1'b0 || dut.state_q !== ST_IDLE) bad = 1'b1;
    end
    check("reset_rdy", 32'(RDY_RX), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("reset_hold", 32'(bad), 32'd0);

    // Idle for 5 us with no request.
    RST   = 1'b0;
    PU_RX = 1'b0;
    bad   = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (RDY_RX !== 1'b0) bad = 1'b1;
    end
    check("idle_rdy_low", 32'(bad), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Power-up held for 125 cycles.
    PU_RX = 1'b1;
    measure_rise("pu", n);
    check("pu_rise_lat", 32'(n), 32'(RISE));
    bad = 1'b0;
    for (int i = n; i < 125; i++) begin
      tick();
      if (RDY_RX !== 1'b1) bad = 1'b1;
    end
    check("pu_stays_high", 32'(bad), 32'd0);

    // Power-down: falls LAT+1 edges after PU_RX drops.
    PU_RX = 1'b0;
    measure_fall(n);
    check("pd_fall_lat", 32'(n), 32'(LAT + 1));
    bad = 1'b0;
    for (int i = n; i < 50; i++) begin
      tick();
      if (RDY_RX !== 1'b0) bad = 1'b1;
    end
    check("pd_stays_low", 32'(bad), 32'd0);

    // Restart after power-down needs the full latency again.
    PU_RX = 1'b1;
    measure_rise("restart", n);
    check("restart_rise_lat", 32'(n), 32'(RISE));

    // Abort during SETTLE, re-raise 5 cycles later.
    PU_RX = 1'b0;
    measure_fall(n);
    check("abort_prep_fall", 32'(n), 32'(LAT + 1));
    repeat (10) tick();
    PU_RX = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (RDY_RX !== 1'b0) bad = 1'b1;
    end
    check("abort_in_settle", 32'(dut.state_q), 32'(ST_SETTLE));
    PU_RX = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RDY_RX !== 1'b0) bad = 1'b1;
    end
    PU_RX = 1'b1;
    measure_rise("abort", n);
    check("abort_no_pulse", 32'(bad), 32'd0);
    check("abort_rise_lat", 32'(n), 32'(RISE));

    // Reset mid-operation while READY: output clears without a clock edge.
    #50;
    RST = 1'b1;
    #1;
    check("midrst_rdy", 32'(RDY_RX), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    tick();
    tick();
    RST = 1'b0;
    measure_rise("midrst", n);
    check("midrst_rise_lat", 32'(n), 32'(RISE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
